fc_link_tx: RTL
===============

// Module: fc_link_tx
// PURPOSE
//  Link-level transmit word generator for one FC port, feeding the 8b/10b PCS as 32b data + 4b K flags.
//  Emits primitive sequences per the link-state machine (fc::state_t); in STATE_AC it muxes frame words from an Avalon-ST sink with fill words.
//  Enforces a minimum primitive-sequence repeat count and a minimum inter-frame fill gap.
//  Handles underrun, and abort when the link leaves STATE_AC mid-frame.
// PARAMETERS
//  MIN_SEQ_REPEAT  12  consecutive words a primitive sequence is held before another may replace it (>=1)
//  MIN_IFG         6   fill words required between EOF and next SOF (>=1)
//  FILL_MODE       0   fill word in STATE_AC: 0 = fc::IDLE, 1 = fc::ARBFF
//  CNT_W           8   width of repeat/gap counters; must hold max(MIN_SEQ_REPEAT, MIN_IFG)
// PORTS
//  clk            in   1   port clock (PCS tx word clock)
//  reset          in   1   synchronous, active-high reset
//  state          in   fc::state_t  current link state
//  in_data        in   32  frame word (SOF..EOF inclusive)
//  in_datak       in   4   K flags for in_data (delimiters 4'b1000, payload 4'b0000)
//  in_valid       in   1   Avalon-ST valid
//  in_startofpacket in 1   first word (SOF) of frame
//  in_endofpacket in   1   last word (EOF) of frame
//  in_ready       out  1   Avalon-ST ready (readyLatency 0)
//  data           out  32  transmit word
//  datak          out  4   K flags for data
//  underrun       out  1   1-cycle pulse: fill inserted mid-frame because in_valid=0
//  abort          out  1   1-cycle pulse: frame truncated by state leaving STATE_AC
// BEHAVIOUR
//  - Outputs registered; data/datak valid 1 clk after inputs sampled.
//  - Reset: data=fc::IDLE, datak=4'b1000, in_ready=0, underrun=0, abort=0; FSM=FILL; seq word=fc::IDLE; rep_cnt=MIN_SEQ_REPEAT (saturated); gap_cnt=MIN_IFG (saturated).
//  - Sequence word map: LR1->LR, LR2->LRR, LR3->IDLE, LF1->OLS, LF2->NOS, OL1->OLS, OL2->LR, OL3->NOS.
//    Any other non-AC state -> IDLE. All sequence/fill words: datak=4'b1000.
//  - Repeat rule: a new seq word is latched only when rep_cnt>=MIN_SEQ_REPEAT. Latching resets rep_cnt to 1; each transmitted word increments rep_cnt, saturating.
//    If state changes earlier, the current word is held until the count completes, then the word for the state at that time is latched.
//  - FSM states:
//    SEQ   : state!=AC; transmit latched seq word; in_ready=0.
//    FILL  : state==AC; transmit fill word; gap_cnt increments, saturating.
//            FILL->FRAME when in_valid & in_startofpacket & gap_cnt>=MIN_IFG; in_ready=1 that cycle and the SOF word is sent.
//            in_valid & !in_startofpacket in FILL: word dropped (in_ready=1), no output effect.
//    FRAME : in_ready=1; in_valid=1 -> pass in_data/in_datak. in_valid=0 -> send fill, pulse underrun.
//            Accepted in_endofpacket -> FILL, gap_cnt=0.
//    DRAIN : entered from FRAME when state!=AC; pulse abort once. in_ready=1; discard until accepted EOP, then SEQ.
//            Output follows SEQ rules throughout.
//  - state leaves AC in FILL -> SEQ next cycle. SEQ->FILL when state==AC and the repeat rule permits; gap_cnt=MIN_IFG on entry.
//  - Same-cycle SOP+EOP in FILL: one-word frame; FSM stays FILL, gap_cnt=0.
//  - Reset mid-frame: immediate return to reset values; no abort pulse; residual sink words handled by the FILL drop rule.
// STRUCTURE
//  - Package fc gains: MIN_SEQ_REPEAT_DEFAULT, MIN_IFG_DEFAULT, typedef enum tx_fsm_t {TX_SEQ, TX_FILL, TX_FRAME, TX_DRAIN}.
//    Also a function seq_word(state_t) returning the mapped primitive.
//  - Sub-module fc_prim_seq_hold: seq word latch + rep_cnt (repeat rule). Parent holds the FSM, gap counter and output mux.
// TESTING
//  1. reset 4 clk then release, state=AC, FILL_MODE=0, in_valid=0 -> data=IDLE, datak=4'b1000 every cycle, in_ready=0.
//  2. Default params; state LR1 for 3 clk then LR2 -> LR sent exactly 12 words, then LRR; no intermediate word.
//  3. AC, 4-word frame ready at t0 with gap saturated -> SOF,P,P,EOF on data at t0+1..t0+4.
//     Back-to-back second frame: its SOF appears only after exactly 6 fill words.
//  4. Mid-frame in_valid=0 for 2 clk -> 2 fill words emitted, underrun high 2 cycles; frame resumes, EOF intact.
//  5. state AC->OL1 after word 2 of 8-word frame -> abort pulses once; remaining 6 words consumed with in_ready=1; data=OLS from next cycle.
//  6. FILL_MODE=1, single-word frame (SOP=EOP=1) -> ARBFF fill, frame word sent, then 6 ARBFF before next SOF accepted.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared Fibre Channel link-level definitions: link states, primitive words and
// the link-state to primitive-sequence map used by the transmit word generator.
package fc;

  typedef enum logic [3:0] {
    STATE_AC  = 4'd0,
    STATE_LR1 = 4'd1,
    STATE_LR2 = 4'd2,
    STATE_LR3 = 4'd3,
    STATE_LF1 = 4'd4,
    STATE_LF2 = 4'd5,
    STATE_OL1 = 4'd6,
    STATE_OL2 = 4'd7,
    STATE_OL3 = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    TX_SEQ   = 2'd0,
    TX_FILL  = 2'd1,
    TX_FRAME = 2'd2,
    TX_DRAIN = 2'd3
  } tx_fsm_t;

  localparam int MIN_SEQ_REPEAT_DEFAULT = 12;
  localparam int MIN_IFG_DEFAULT        = 6;

  // Ordered sets, K28.5 first (byte 3 carries the K flag).
  localparam logic [31:0] IDLE  = 32'hBC95_B5B5;
  localparam logic [31:0] ARBFF = 32'hBC94_FFFF;
  localparam logic [31:0] LR    = 32'hBC49_BF49;
  localparam logic [31:0] LRR   = 32'hBC35_BF49;
  localparam logic [31:0] OLS   = 32'hBC35_8A55;
  localparam logic [31:0] NOS   = 32'hBC55_BF45;

  localparam logic [3:0] K_DELIM = 4'b1000;

  function automatic logic [31:0] seq_word(input state_t s);
    case (s)
      STATE_LR1: seq_word = LR;
      STATE_LR2: seq_word = LRR;
      STATE_LR3: seq_word = IDLE;
      STATE_LF1: seq_word = OLS;
      STATE_LF2: seq_word = NOS;
      STATE_OL1: seq_word = OLS;
      STATE_OL2: seq_word = LR;
      STATE_OL3: seq_word = NOS;
      default:   seq_word = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fc_prim_seq_hold.sv
// Primitive-sequence latch: holds the current sequence word for at least
// MIN_SEQ_REPEAT transmitted words before a different one may replace it.
module fc_prim_seq_hold
  import fc::*;
#(
  parameter int MIN_SEQ_REPEAT = MIN_SEQ_REPEAT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  state_t      state,
  input  logic        seq_req,
  output logic [31:0] word,
  output logic        rep_ok
);

  localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(MIN_SEQ_REPEAT);

  logic [31:0]      cur_word;
  logic [CNT_W-1:0] rep_cnt;
  logic [31:0]      want;
  logic             do_latch;

  assign want     = seq_word(state);
  assign rep_ok   = (rep_cnt >= REP_MAX);
  assign do_latch = seq_req && rep_ok && (want != cur_word);
  // The word that goes out this cycle; a fresh latch is transmitted immediately.
  assign word     = do_latch ? want : cur_word;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_word <= IDLE;
      rep_cnt  <= REP_MAX;
    end else if (do_latch) begin
      cur_word <= want;
      rep_cnt  <= CNT_W'(1);
    end else if (!rep_ok) begin
      rep_cnt  <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fc_link_tx.sv
// FC link transmit word generator: primitive sequences outside STATE_AC, frames
// from an Avalon-ST sink muxed with fill words inside it, registered to the PCS.
module fc_link_tx
  import fc::*;
#(
  parameter int MIN_SEQ_REPEAT = MIN_SEQ_REPEAT_DEFAULT,
  parameter int MIN_IFG        = MIN_IFG_DEFAULT,
  parameter int FILL_MODE      = 0,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  state_t      state,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic        in_ready,
  output logic [31:0] data,
  output logic [3:0]  datak,
  output logic        underrun,
  output logic        abort
);

  localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(MIN_IFG);
  localparam logic [31:0]      FILL_WORD = (FILL_MODE != 0) ? ARBFF : IDLE;

  tx_fsm_t          fsm, fsm_nx;
  logic [CNT_W-1:0] gap_cnt, gap_nx;
  logic [31:0]      data_nx, hold_word;
  logic [3:0]       datak_nx;
  logic             underrun_nx, abort_nx;
  logic             seq_req, rep_ok, in_ac, gap_ok, eop_accept;

  assign in_ac      = (state == STATE_AC);
  assign gap_ok     = (gap_cnt >= GAP_MAX);
  assign eop_accept = in_valid && in_endofpacket;

  fc_prim_seq_hold #(
    .MIN_SEQ_REPEAT (MIN_SEQ_REPEAT),
    .CNT_W          (CNT_W)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .state   (state),
    .seq_req (seq_req),
    .word    (hold_word),
    .rep_ok  (rep_ok)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    fsm_nx      = fsm;
    gap_nx      = gap_cnt;
    data_nx     = FILL_WORD;
    datak_nx    = K_DELIM;
    underrun_nx = 1'b0;
    abort_nx    = 1'b0;
    in_ready    = 1'b0;
    seq_req     = 1'b0;

    case (fsm)
      TX_SEQ: begin
        gap_nx = GAP_MAX;
        if (in_ac && rep_ok) begin
          fsm_nx = TX_FILL;
        end else begin
          seq_req = !in_ac;
          data_nx = hold_word;
        end
      end

      TX_FILL: begin
        if (!in_ac) begin
          seq_req = 1'b1;
          data_nx = hold_word;
          fsm_nx  = TX_SEQ;
        end else begin
          if (!gap_ok) gap_nx = gap_cnt + 1'b1;
          if (in_valid && in_startofpacket) begin
            if (gap_ok) begin
              in_ready = 1'b1;
              data_nx  = in_data;
              datak_nx = in_datak;
              if (in_endofpacket) gap_nx = '0;
              else                fsm_nx = TX_FRAME;
            end
          end else if (in_valid) begin
            // Stray mid-frame words (e.g. left over after reset) are drained silently.
            in_ready = 1'b1;
          end
        end
      end

      TX_FRAME: begin
        in_ready = 1'b1;
        if (!in_ac) begin
          seq_req  = 1'b1;
          data_nx  = hold_word;
          abort_nx = 1'b1;
          fsm_nx   = eop_accept ? TX_SEQ : TX_DRAIN;
        end else if (in_valid) begin
          data_nx  = in_data;
          datak_nx = in_datak;
          if (in_endofpacket) begin
            fsm_nx = TX_FILL;
            gap_nx = '0;
          end
        end else begin
          underrun_nx = 1'b1;
        end
      end

      TX_DRAIN: begin
        in_ready = 1'b1;
        seq_req  = !in_ac;
        data_nx  = hold_word;
        if (eop_accept) fsm_nx = TX_SEQ;
      end

      default: fsm_nx = TX_FILL;
    endcase

    if (reset) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm      <= TX_FILL;
      gap_cnt  <= GAP_MAX;
      data     <= IDLE;
      datak    <= K_DELIM;
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      fsm      <= fsm_nx;
      gap_cnt  <= gap_nx;
      data     <= data_nx;
      datak    <= datak_nx;
      underrun <= underrun_nx;
      abort    <= abort_nx;
    end
  end

endmodule
